rob_retire: RTL and testbench
=============================

// Module: rob_retire
// PURPOSE
//  In-order retirement end of the rename path: holds renamed instructions from allocation until completion.
//  Retires the head entry and commits its mapping to the RRAT.
//  Returns the previous physical register to the free list via rrat_free/rrat_free_reg, the pair Rename consumes.
//  Sits after Rename, beside issue/LSQ; drives the pipeline flush on a mispredicted branch.
// PARAMETERS
//  DEPTH     16  ROB entries; power of two, >=2
//  PTR_W     4   log2(DEPTH); pointers carry one extra wrap bit (PTR_W+1)
//  PHYS_W    6   physical register index width (64 physical registers)
// PORTS
//  CLK              in   1       clock, posedge
//  RESET            in   1       reset, asynchronous, active-low
//  alloc_valid      in   1       Rename presents a new entry
//  alloc_pc         in   32      instruction PC
//  alloc_regwrite   in   1       entry writes an architectural register
//  alloc_arch_reg   in   5       architectural destination
//  alloc_new_phys   in   PHYS_W  newly mapped physical register
//  alloc_old_phys   in   PHYS_W  previous FRAT mapping of alloc_arch_reg
//  alloc_tag        out  PTR_W   index given to the entry accepted this cycle (tail)
//  rob_halt         out  1       full; Rename must stall (combinational)
//  cmpl_valid       in   1       execution reports completion
//  cmpl_tag         in   PTR_W   completing entry
//  cmpl_mispredict  in   1       completing entry is a mispredicted branch/jump
//  retire_valid     out  1       one entry retired (registered pulse)
//  retire_pc        out  32      PC of retired entry
//  rrat_remap       out  1       RRAT write enable
//  rrat_arch_reg    out  5       RRAT index
//  rrat_new_phys    out  PHYS_W  RRAT value
//  rrat_free        out  1       free-list return valid
//  rrat_free_reg    out  PHYS_W  physical register returned
//  flush_out        out  1       one-cycle pipeline flush pulse
//  stat_retired     out  32      (ROB_STATS_EN only) retired-instruction count
//  stat_flushes     out  16      (ROB_STATS_EN only) flush count
// BEHAVIOUR
//  Reset: all registered outputs 0. head = tail = count = 0. All entry valid/done/mispred bits 0.
//  Entry fields: valid, done, mispred, regwrite, arch[4:0], new_phys, old_phys, pc[31:0].
//  rob_halt = (count == DEPTH). Use count at cycle start; a same-cycle retire does not admit an alloc.
//  Allocate when alloc_valid & !rob_halt & !flush_pending.
//    Write entry[tail] with valid=1, done=0, mispred=0; tail++ (wraps modulo DEPTH).
//  Complete: on cmpl_valid with entry[cmpl_tag].valid, set done=1 and mispred=cmpl_mispredict.
//    A completion to an invalid entry is ignored.
//  Retire, one per cycle: when entry[head].valid & done, next edge drives retire_valid=1 and retire_pc.
//    Same edge: rrat_remap = rrat_free = regwrite & (arch!=0).
//    Same edge: rrat_arch_reg = arch, rrat_new_phys = new_phys, rrat_free_reg = old_phys.
//    Clear entry valid; head++.
//    Data outputs hold their last value when not valid. Latency: done seen at edge N gives retire at edge N+1.
//  Completion and retire of the same entry in one cycle: done is set, retire follows next cycle.
//  Mispredict at head: entry retires normally (link writes commit) and flush_pending is set.
//    Next edge: flush_out=1; all valid bits cleared; head = tail = count = 0.
//    Allocs while flush_pending or flush_out are dropped.
//  count = count + alloc_accepted - retired, with the flush clear taking priority.
//  Pointer wrap: full/empty are resolved by the wrap bit. count==0 means empty; no retire occurs when empty.
//  RESET asserted mid-operation: immediate clear; in-flight retire and flush pulses are lost.
// CONFIGURATION
//  ROB_STATS_EN defined: stat_retired increments on each retire_valid; stat_flushes increments on each flush_out.
//    Both saturate and reset to 0.
//  ROB_STATS_EN undefined: stat_* ports absent, no counters built.
// STRUCTURE
//  Shared header rob_defs.vh: ROB_DEPTH, ROB_PTR_W, PHYS_W and the entry field bit offsets.
//    Rename and issue include the same header.
//  One sub-module, rob_ptr: wrap-bit circular pointer with inc/clear. Instantiated twice (head, tail).
// TESTING
//  Alloc tags 0..3 (arch 8, new 40, old 8), complete 2,0,1,3.
//    -> retires in order 0,1,2,3 on consecutive edges from the first eligible edge; rrat_free_reg=8 each time.
//  Fill 16 entries -> rob_halt=1. Alloc held 3 cycles: no tail move.
//    Retire head -> rob_halt=0 next cycle, alloc accepted with tag 0.
//  Mispredict on tag 1 of 5 in flight, 0 and 1 complete -> retire 0, retire 1, flush_out=1.
//    Then count=0 and alloc_tag=0; entries 2-4 never retire.
//  Entry with arch 0 or regwrite=0 retires -> retire_valid=1, rrat_remap=0, rrat_free=0.
//  Completion to an unallocated tag, then RESET pulled low mid-retire.
//    -> no retire from the stale tag; all outputs 0 immediately, halt=0.
//  With ROB_STATS_EN: 20 retires across one wrap plus 1 flush -> stat_retired=20, stat_flushes=1.

Source files
------------

// File: rtl/rob_retire_pkg.sv
// Shared ROB definitions: default geometry, flush sequencer states and
// the RRAT-commit predicate used wherever a retiring entry is committed.
package rob_retire_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_PTR_W  = 4;
    localparam int ROB_PHYS_W = 6;
    localparam int ARCH_W     = 5;
    localparam int PC_W       = 32;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_PEND = 2'd1,
        FL_OUT  = 2'd2
    } flush_st_t;

    // x0 is hardwired; committing it would leak a physical register.
    function automatic logic rrat_writes(
        input logic              regwrite,
        input logic [ARCH_W-1:0] arch
    );
        return regwrite & (arch != '0);
    endfunction

endpackage

// File: rtl/rob_retire_ptr.sv
// Circular ROB pointer with one extra wrap bit; increment and clear.
// The wrap bit lets full and empty be told apart when indices match.
module rob_retire_ptr #(
    parameter int PTR_W = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           inc,
    input  logic           clr,
    output logic [PTR_W:0] ptr
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer retirement: in-order retire, RRAT commit, mispredict flush.
// Optional ROB_STATS_EN adds saturating retire/flush counters.
module rob_retire
    import rob_retire_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int PTR_W  = ROB_PTR_W,
    parameter int PHYS_W = ROB_PHYS_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              alloc_valid,
    input  logic [31:0]       alloc_pc,
    input  logic              alloc_regwrite,
    input  logic [4:0]        alloc_arch_reg,
    input  logic [PHYS_W-1:0] alloc_new_phys,
    input  logic [PHYS_W-1:0] alloc_old_phys,
    output logic [PTR_W-1:0]  alloc_tag,
    output logic              rob_halt,
    input  logic              cmpl_valid,
    input  logic [PTR_W-1:0]  cmpl_tag,
    input  logic              cmpl_mispredict,
    output logic              retire_valid,
    output logic [31:0]       retire_pc,
    output logic              rrat_remap,
    output logic [4:0]        rrat_arch_reg,
    output logic [PHYS_W-1:0] rrat_new_phys,
    output logic              rrat_free,
    output logic [PHYS_W-1:0] rrat_free_reg,
    output logic              flush_out
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]       stat_retired,
    output logic [15:0]       stat_flushes
`endif
);

    logic [PTR_W:0]     head;
    logic [PTR_W:0]     tail;
    logic [PTR_W-1:0]   head_idx;
    logic [PTR_W-1:0]   tail_idx;
    logic               full;
    logic               empty;

    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   ent_done;
    logic [DEPTH-1:0]   ent_mispred;

    logic               ent_rw   [DEPTH];
    logic [4:0]         ent_arch [DEPTH];
    logic [PHYS_W-1:0]  ent_new  [DEPTH];
    logic [PHYS_W-1:0]  ent_old  [DEPTH];
    logic [31:0]        ent_pc   [DEPTH];

    flush_st_t          fl_q;
    flush_st_t          fl_d;
    logic               flush_pending;
    logic               flush_now;
    logic               alloc_block;

    logic               alloc_ok;
    logic               cmpl_hit;
    logic               retire_now;
    logic               commit;

    assign head_idx = head[PTR_W-1:0];
    assign tail_idx = tail[PTR_W-1:0];
    assign empty    = (head == tail);
    assign full     = (head[PTR_W] != tail[PTR_W])
                   && (head_idx == tail_idx);

    assign alloc_tag = tail_idx;
    assign rob_halt  = full;

    assign alloc_ok   = alloc_valid & ~full & ~alloc_block;
    assign cmpl_hit   = cmpl_valid & ent_valid[cmpl_tag];
    // Younger entries behind a retiring mispredict are wrong-path.
    assign retire_now = ~empty & ent_valid[head_idx]
                      & ent_done[head_idx] & ~flush_pending;
    assign commit     = retire_now
                      & rrat_writes(ent_rw[head_idx], ent_arch[head_idx]);

    rob_retire_ptr #(
        .PTR_W (PTR_W)
    ) u_head (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (retire_now),
        .clr   (flush_pending),
        .ptr   (head)
    );

    rob_retire_ptr #(
        .PTR_W (PTR_W)
    ) u_tail (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (alloc_ok),
        .clr   (flush_pending),
        .ptr   (tail)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fl_q <= FL_IDLE;
        end else begin
            fl_q <= fl_d;
        end
    end

    always_comb begin
        fl_d = fl_q;
        unique case (fl_q)
            FL_IDLE: begin
                if (retire_now && ent_mispred[head_idx]) begin
                    fl_d = FL_PEND;
                end
            end
            FL_PEND: fl_d = FL_OUT;
            FL_OUT:  fl_d = FL_IDLE;
            default: fl_d = FL_IDLE;
        endcase
    end

    always_comb begin
        flush_pending = 1'b0;
        flush_now     = 1'b0;
        unique case (fl_q)
            FL_PEND: flush_pending = 1'b1;
            FL_OUT:  flush_now     = 1'b1;
            default: ;
        endcase
        alloc_block = flush_pending | flush_now;
    end

    assign flush_out = flush_now;

    // Order matters: retire clears after completion, alloc initialises last.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ent_valid   <= '0;
            ent_done    <= '0;
            ent_mispred <= '0;
        end else if (flush_pending) begin
            ent_valid   <= '0;
            ent_done    <= '0;
            ent_mispred <= '0;
        end else begin
            if (cmpl_hit) begin
                ent_done[cmpl_tag]    <= 1'b1;
                ent_mispred[cmpl_tag] <= cmpl_mispredict;
            end
            if (retire_now) begin
                ent_valid[head_idx] <= 1'b0;
            end
            if (alloc_ok) begin
                ent_valid[tail_idx]   <= 1'b1;
                ent_done[tail_idx]    <= 1'b0;
                ent_mispred[tail_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (alloc_ok) begin
            ent_rw[tail_idx]   <= alloc_regwrite;
            ent_arch[tail_idx] <= alloc_arch_reg;
            ent_new[tail_idx]  <= alloc_new_phys;
            ent_old[tail_idx]  <= alloc_old_phys;
            ent_pc[tail_idx]   <= alloc_pc;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retire_valid  <= 1'b0;
            retire_pc     <= '0;
            rrat_remap    <= 1'b0;
            rrat_free     <= 1'b0;
            rrat_arch_reg <= '0;
            rrat_new_phys <= '0;
            rrat_free_reg <= '0;
        end else begin
            retire_valid <= retire_now;
            rrat_remap   <= commit;
            rrat_free    <= commit;
            if (retire_now) begin
                retire_pc     <= ent_pc[head_idx];
                rrat_arch_reg <= ent_arch[head_idx];
                rrat_new_phys <= ent_new[head_idx];
                rrat_free_reg <= ent_old[head_idx];
            end
        end
    end

`ifdef ROB_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_retired <= '0;
            stat_flushes <= '0;
        end else begin
            if (retire_valid && (stat_retired != '1)) begin
                stat_retired <= stat_retired + 32'd1;
            end
            if (flush_out && (stat_flushes != '1)) begin
                stat_flushes <= stat_flushes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: vector table plus corner sequences.
// Define ROB_STATS_EN for both RTL and bench to cover the counters.
module tb_rob_retire;

    logic        CLK;
    logic        RESET;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_regwrite;
    logic [4:0]  alloc_arch_reg;
    logic [5:0]  alloc_new_phys;
    logic [5:0]  alloc_old_phys;
    logic [3:0]  alloc_tag;
    logic        rob_halt;
    logic        cmpl_valid;
    logic [3:0]  cmpl_tag;
    logic        cmpl_mispredict;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        rrat_remap;
    logic [4:0]  rrat_arch_reg;
    logic [5:0]  rrat_new_phys;
    logic        rrat_free;
    logic [5:0]  rrat_free_reg;
    logic        flush_out;
`ifdef ROB_STATS_EN
    logic [31:0] stat_retired;
    logic [15:0] stat_flushes;
`endif

    int checks;
    int failures;

    rob_retire dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .alloc_valid     (alloc_valid),
        .alloc_pc        (alloc_pc),
        .alloc_regwrite  (alloc_regwrite),
        .alloc_arch_reg  (alloc_arch_reg),
        .alloc_new_phys  (alloc_new_phys),
        .alloc_old_phys  (alloc_old_phys),
        .alloc_tag       (alloc_tag),
        .rob_halt        (rob_halt),
        .cmpl_valid      (cmpl_valid),
        .cmpl_tag        (cmpl_tag),
        .cmpl_mispredict (cmpl_mispredict),
        .retire_valid    (retire_valid),
        .retire_pc       (retire_pc),
        .rrat_remap      (rrat_remap),
        .rrat_arch_reg   (rrat_arch_reg),
        .rrat_new_phys   (rrat_new_phys),
        .rrat_free       (rrat_free),
        .rrat_free_reg   (rrat_free_reg),
        .flush_out       (flush_out)
`ifdef ROB_STATS_EN
        ,
        .stat_retired    (stat_retired),
        .stat_flushes    (stat_flushes)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        av;
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  arch;
        logic [5:0]  np;
        logic [5:0]  op;
        logic        cv;
        logic [3:0]  ct;
        logic        cm;
        logic [3:0]  e_tag;
        logic        e_halt;
        logic        e_rv;
        logic [31:0] e_pc;
        logic        e_rm;
        logic        e_fr;
        logic [4:0]  e_arch;
        logic [5:0]  e_np;
        logic [5:0]  e_freg;
    } vec_t;

    localparam int NV = 16;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t vi();
        vec_t r;
        r.av = 1'b0; r.pc = 32'h0; r.rw = 1'b0; r.arch = 5'd0;
        r.np = 6'd0; r.op = 6'd0; r.cv = 1'b0; r.ct = 4'd0;
        r.cm = 1'b0; r.e_tag = 4'd0; r.e_halt = 1'b0; r.e_rv = 1'b0;
        r.e_pc = 32'h0; r.e_rm = 1'b0; r.e_fr = 1'b0;
        r.e_arch = 5'd0; r.e_np = 6'd0; r.e_freg = 6'd0;
        return r;
    endfunction

    function automatic vec_t va(input logic [31:0] pc, input logic rw,
                                input logic [4:0] arch,
                                input logic [5:0] np, input logic [5:0] op);
        vec_t r = vi();
        r.av = 1'b1; r.pc = pc; r.rw = rw; r.arch = arch;
        r.np = np; r.op = op;
        return r;
    endfunction

    function automatic vec_t vc(input logic [3:0] tag, input logic mis);
        vec_t r = vi();
        r.cv = 1'b1; r.ct = tag; r.cm = mis;
        return r;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic [3:0] tag,
                                input logic halt, input logic rv,
                                input logic [31:0] pc, input logic rm,
                                input logic fr, input logic [4:0] arch,
                                input logic [5:0] np, input logic [5:0] freg);
        vec_t r = v;
        r.e_tag = tag; r.e_halt = halt; r.e_rv = rv; r.e_pc = pc;
        r.e_rm = rm; r.e_fr = fr; r.e_arch = arch; r.e_np = np;
        r.e_freg = freg;
        return r;
    endfunction

    task automatic idle_inputs();
        alloc_valid     = 1'b0;
        alloc_pc        = 32'h0;
        alloc_regwrite  = 1'b0;
        alloc_arch_reg  = 5'd0;
        alloc_new_phys  = 6'd0;
        alloc_old_phys  = 6'd0;
        cmpl_valid      = 1'b0;
        cmpl_tag        = 4'd0;
        cmpl_mispredict = 1'b0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b0;
        cyc();
        cyc();
        RESET = 1'b1;
    endtask

    task automatic drive_alloc(input logic [31:0] pc, input logic rw,
                               input logic [4:0] arch,
                               input logic [5:0] np, input logic [5:0] op);
        alloc_valid    = 1'b1;
        alloc_pc       = pc;
        alloc_regwrite = rw;
        alloc_arch_reg = arch;
        alloc_new_phys = np;
        alloc_old_phys = op;
    endtask

    task automatic drive_cmpl(input logic [3:0] tag, input logic mis);
        cmpl_valid      = 1'b1;
        cmpl_tag        = tag;
        cmpl_mispredict = mis;
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        idle_inputs();
        RESET = 1'b0;
        #12;
        chk("rst_rv", 32'(retire_valid), 32'd0);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_halt", 32'(rob_halt), 32'd0);
        chk("rst_tag", 32'(alloc_tag), 32'd0);
        chk("rst_remap", 32'(rrat_remap), 32'd0);
        chk("rst_free", 32'(rrat_free), 32'd0);
        chk("rst_pc", retire_pc, 32'h0);
        cyc();
        RESET = 1'b1;

        // Out-of-order completion retires in order; x0/no-write commits nothing
        tv[0]  = ex(va(32'h100, 1'b1, 5'd8, 6'd40, 6'd8),
                    4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        tv[1]  = ex(va(32'h104, 1'b1, 5'd8, 6'd40, 6'd8),
                    4'd1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        tv[2]  = ex(va(32'h108, 1'b1, 5'd8, 6'd40, 6'd8),
                    4'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        tv[3]  = ex(va(32'h10C, 1'b1, 5'd8, 6'd40, 6'd8),
                    4'd3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        tv[4]  = ex(vc(4'd2, 1'b0),
                    4'd4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        tv[5]  = ex(vc(4'd0, 1'b0),
                    4'd4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        tv[6]  = ex(vc(4'd1, 1'b0),
                    4'd4, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 5'd8, 6'd40, 6'd8);
        tv[7]  = ex(vc(4'd3, 1'b0),
                    4'd4, 1'b0, 1'b1, 32'h104, 1'b1, 1'b1, 5'd8, 6'd40, 6'd8);
        tv[8]  = ex(vi(),
                    4'd4, 1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 5'd8, 6'd40, 6'd8);
        tv[9]  = ex(vi(),
                    4'd4, 1'b0, 1'b1, 32'h10C, 1'b1, 1'b1, 5'd8, 6'd40, 6'd8);
        tv[10] = ex(vi(),
                    4'd4, 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0, 5'd8, 6'd40, 6'd8);
        tv[11] = ex(va(32'h200, 1'b1, 5'd0, 6'd41, 6'd9),
                    4'd4, 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0, 5'd8, 6'd40, 6'd8);
        v = va(32'h204, 1'b0, 5'd5, 6'd42, 6'd10);
        v.cv = 1'b1;
        v.ct = 4'd4;
        tv[12] = ex(v,
                    4'd5, 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0, 5'd8, 6'd40, 6'd8);
        tv[13] = ex(vc(4'd5, 1'b0),
                    4'd6, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 5'd0, 6'd41, 6'd9);
        tv[14] = ex(vi(),
                    4'd6, 1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 5'd5, 6'd42, 6'd10);
        tv[15] = ex(vi(),
                    4'd6, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0, 5'd5, 6'd42, 6'd10);

        for (int i = 0; i < NV; i++) begin
            v = tv[i];
            alloc_valid     = v.av;
            alloc_pc        = v.pc;
            alloc_regwrite  = v.rw;
            alloc_arch_reg  = v.arch;
            alloc_new_phys  = v.np;
            alloc_old_phys  = v.op;
            cmpl_valid      = v.cv;
            cmpl_tag        = v.ct;
            cmpl_mispredict = v.cm;
            #1;
            chk($sformatf("v%0d_tag", i), 32'(alloc_tag), 32'(v.e_tag));
            chk($sformatf("v%0d_halt", i), 32'(rob_halt), 32'(v.e_halt));
            cyc();
            chk($sformatf("v%0d_rv", i), 32'(retire_valid), 32'(v.e_rv));
            chk($sformatf("v%0d_pc", i), retire_pc, v.e_pc);
            chk($sformatf("v%0d_remap", i), 32'(rrat_remap), 32'(v.e_rm));
            chk($sformatf("v%0d_free", i), 32'(rrat_free), 32'(v.e_fr));
            chk($sformatf("v%0d_arch", i), 32'(rrat_arch_reg), 32'(v.e_arch));
            chk($sformatf("v%0d_newp", i), 32'(rrat_new_phys), 32'(v.e_np));
            chk($sformatf("v%0d_freg", i), 32'(rrat_free_reg), 32'(v.e_freg));
            chk($sformatf("v%0d_flush", i), 32'(flush_out), 32'd0);
        end

        // Fill to full, hold alloc against halt, then one retire reopens a slot
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_alloc(32'h300 + 32'(4 * i), 1'b1, 5'd2, 6'(i), 6'd1);
            #1;
            chk($sformatf("fill_tag%0d", i), 32'(alloc_tag), 32'(i));
            chk($sformatf("fill_halt%0d", i), 32'(rob_halt), 32'd0);
            cyc();
        end
        drive_alloc(32'h3F0, 1'b1, 5'd2, 6'd50, 6'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("full_halt%0d", i), 32'(rob_halt), 32'd1);
            chk($sformatf("full_tag%0d", i), 32'(alloc_tag), 32'd0);
            cyc();
        end
        drive_cmpl(4'd0, 1'b0);
        cyc();
        cmpl_valid = 1'b0;
        chk("full_halt_b", 32'(rob_halt), 32'd1);
        cyc();
        chk("full_ret_rv", 32'(retire_valid), 32'd1);
        chk("full_ret_pc", retire_pc, 32'h300);
        chk("reopen_halt", 32'(rob_halt), 32'd0);
        chk("reopen_tag", 32'(alloc_tag), 32'd0);
        cyc();
        chk("refull_halt", 32'(rob_halt), 32'd1);
        chk("refull_tag", 32'(alloc_tag), 32'd1);
        idle_inputs();

        // Mispredict on tag 1 of 5 in flight
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alloc(32'h500 + 32'(4 * i), 1'b1, 5'd3,
                        6'd20 + 6'(i), 6'd10 + 6'(i));
            cyc();
        end
        idle_inputs();
        drive_cmpl(4'd0, 1'b0);
        cyc();
        drive_cmpl(4'd1, 1'b1);
        cyc();
        chk("mp_r0_rv", 32'(retire_valid), 32'd1);
        chk("mp_r0_pc", retire_pc, 32'h500);
        chk("mp_r0_freg", 32'(rrat_free_reg), 32'd10);
        drive_cmpl(4'd3, 1'b0);
        cyc();
        chk("mp_r1_rv", 32'(retire_valid), 32'd1);
        chk("mp_r1_pc", retire_pc, 32'h504);
        chk("mp_r1_remap", 32'(rrat_remap), 32'd1);
        chk("mp_r1_flush", 32'(flush_out), 32'd0);
        drive_cmpl(4'd2, 1'b0);
        drive_alloc(32'h600, 1'b1, 5'd4, 6'd30, 6'd4);
        cyc();
        chk("mp_flush", 32'(flush_out), 32'd1);
        chk("mp_fl_rv", 32'(retire_valid), 32'd0);
        chk("mp_fl_tag", 32'(alloc_tag), 32'd0);
        chk("mp_fl_halt", 32'(rob_halt), 32'd0);
        drive_cmpl(4'd4, 1'b0);
        cyc();
        chk("mp_fl_end", 32'(flush_out), 32'd0);
        chk("mp_drop_tag", 32'(alloc_tag), 32'd0);
        chk("mp_post_rv", 32'(retire_valid), 32'd0);
        cmpl_valid = 1'b0;
        drive_alloc(32'h700, 1'b1, 5'd4, 6'd31, 6'd4);
        cyc();
        alloc_valid = 1'b0;
        chk("mp_new_tag", 32'(alloc_tag), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("mp_quiet%0d", i), 32'(retire_valid), 32'd0);
        end
        drive_cmpl(4'd0, 1'b0);
        cyc();
        cmpl_valid = 1'b0;
        cyc();
        chk("mp_new_rv", 32'(retire_valid), 32'd1);
        chk("mp_new_pc", retire_pc, 32'h700);

        // Completion to an unallocated tag is dropped; async reset mid-retire
        do_reset();
        drive_cmpl(4'd0, 1'b0);
        cyc();
        idle_inputs();
        drive_alloc(32'h800, 1'b1, 5'd7, 6'd33, 6'd7);
        cyc();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("stale_rv%0d", i), 32'(retire_valid), 32'd0);
        end
        drive_cmpl(4'd0, 1'b0);
        cyc();
        idle_inputs();
        cyc();
        chk("pre_rst_rv", 32'(retire_valid), 32'd1);
        chk("pre_rst_remap", 32'(rrat_remap), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_rv", 32'(retire_valid), 32'd0);
        chk("arst_pc", retire_pc, 32'h0);
        chk("arst_remap", 32'(rrat_remap), 32'd0);
        chk("arst_free", 32'(rrat_free), 32'd0);
        chk("arst_freg", 32'(rrat_free_reg), 32'd0);
        chk("arst_flush", 32'(flush_out), 32'd0);
        chk("arst_halt", 32'(rob_halt), 32'd0);
        chk("arst_tag", 32'(alloc_tag), 32'd0);
        cyc();
        RESET = 1'b1;

`ifdef ROB_STATS_EN
        do_reset();
        chk("st_rst_ret", stat_retired, 32'd0);
        chk("st_rst_fl", 32'(stat_flushes), 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive_alloc(32'h900 + 32'(4 * i), 1'b1, 5'd9, 6'd12, 6'd9);
            cyc();
            idle_inputs();
            drive_cmpl(4'(i % 16), (i == 19));
            cyc();
            idle_inputs();
            cyc();
            cyc();
            cyc();
        end
        chk("st_retired", stat_retired, 32'd20);
        chk("st_flushes", 32'(stat_flushes), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
